// File: rtl/pbit_histogram_collector.sv
// pbit_histogram_collector: clears a 2**NUM_OUT-bin histogram, counts p-bit
// samples into it, then streams out the non-zero bins over a valid/ready port.
module pbit_histogram_collector #(
    parameter int NUM_OUT = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               sample_valid,
    input  logic [NUM_OUT-1:0] sample_data,
    input  logic               start,
    input  logic [31:0]        num_samples,
    output logic               busy,
    output logic               done,
    output logic               sat_flag,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [NUM_OUT-1:0] rd_pattern,
    output logic [CNT_W-1:0]   rd_count,
    output logic               rd_last
);
    localparam int NBINS  = 2**NUM_OUT;
    localparam int STAGES = 1;

    typedef enum logic [1:0] {IDLE, CLEAR, COLLECT, DUMP} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]   mem [NBINS];
    logic [CNT_W-1:0]   ram_q;
    logic [31:0]        num_lat, sample_cnt;
    logic [NUM_OUT-1:0] clr_addr;
    // vld_pipe[0]: read data for s1_addr is in ram_q; vld_pipe[1]: lw_* holds last write
    logic [STAGES:0]    vld_pipe;
    logic [NUM_OUT-1:0] s1_addr, lw_addr;
    logic [CNT_W-1:0]   lw_data;
    logic [NUM_OUT:0]   scan_addr;
    logic               d_vld, pend_vld;
    logic [NUM_OUT-1:0] d_addr, pend_addr;
    logic [CNT_W-1:0]   pend_cnt;

    logic               start_acc, accept, at_max, fire, out_free;
    logic               d_take, scan_more, issue, flush, dump_end;
    logic               we, ren;
    logic [NUM_OUT-1:0] waddr, raddr;
    logic [CNT_W-1:0]   wdata, cur, inc;

    // Datapath control: RMW increment with forwarding, and the dump scan.
    // Dump keeps one non-zero bin pending so rd_last is known when it is sent.
    always_comb begin
        start_acc = (state_q == IDLE) && start;
        accept    = (state_q == COLLECT) && sample_valid && (sample_cnt != num_lat);
        cur       = (vld_pipe[1] && lw_addr == s1_addr) ? lw_data : ram_q;
        at_max    = &cur;
        inc       = at_max ? cur : cur + CNT_W'(1);
        fire      = rd_valid && rd_ready;
        out_free  = !rd_valid || fire;
        d_take    = d_vld && ((ram_q == '0) || !pend_vld || out_free);
        scan_more = !scan_addr[NUM_OUT];
        issue     = (state_q == DUMP) && scan_more && (!d_vld || d_take);
        flush     = (state_q == DUMP) && !scan_more && !d_vld && pend_vld && out_free;
        dump_end  = (state_q == DUMP) && !scan_more && !d_vld && !pend_vld && out_free;
        we        = (state_q == CLEAR) || vld_pipe[0];
        waddr     = (state_q == CLEAR) ? clr_addr : s1_addr;
        wdata     = (state_q == CLEAR) ? '0 : inc;
        ren       = accept || issue;
        raddr     = accept ? sample_data : scan_addr[NUM_OUT-1:0];
    end

    // Bin RAM: one write port, registered read (contents not reset).
    always_ff @(posedge clk) begin
        if (we)  mem[waddr] <= wdata;
        if (ren) ram_q <= mem[raddr];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; COLLECT leaves only once the last increment has been written.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   if (&clr_addr) state_d = (num_lat == 32'd0) ? DUMP : COLLECT;
            COLLECT: if (sample_cnt == num_lat && !vld_pipe[0]) state_d = DUMP;
            DUMP:    if (dump_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Run bookkeeping, increment pipeline, dump pending/output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_lat    <= '0;
            sample_cnt <= '0;
            clr_addr   <= '0;
            vld_pipe   <= '0;
            s1_addr    <= '0;
            lw_addr    <= '0;
            lw_data    <= '0;
            scan_addr  <= '0;
            d_vld      <= 1'b0;
            d_addr     <= '0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_cnt   <= '0;
            sat_flag   <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_pattern <= '0;
            rd_count   <= '0;
            rd_last    <= 1'b0;
        end else begin
            done     <= dump_end;
            vld_pipe <= {vld_pipe[STAGES-1:0], accept};
            s1_addr  <= sample_data;
            lw_addr  <= s1_addr;
            lw_data  <= inc;
            if (start_acc) begin
                num_lat    <= num_samples;
                sample_cnt <= '0;
                sat_flag   <= 1'b0;
                clr_addr   <= '0;
                scan_addr  <= '0;
                d_vld      <= 1'b0;
                pend_vld   <= 1'b0;
            end
            if (state_q == CLEAR) clr_addr <= clr_addr + NUM_OUT'(1);
            if (accept) sample_cnt <= sample_cnt + 32'd1;
            if (vld_pipe[0] && at_max) sat_flag <= 1'b1;

            if (issue) begin
                d_vld     <= 1'b1;
                d_addr    <= scan_addr[NUM_OUT-1:0];
                scan_addr <= scan_addr + (NUM_OUT+1)'(1);
            end else if (d_take) begin
                d_vld <= 1'b0;
            end

            if (fire) rd_valid <= 1'b0;
            if (d_take && ram_q != '0) begin
                if (pend_vld) begin
                    rd_valid   <= 1'b1;
                    rd_pattern <= pend_addr;
                    rd_count   <= pend_cnt;
                    rd_last    <= 1'b0;
                end
                pend_vld  <= 1'b1;
                pend_addr <= d_addr;
                pend_cnt  <= ram_q;
            end else if (flush) begin
                rd_valid   <= 1'b1;
                rd_pattern <= pend_addr;
                rd_count   <= pend_cnt;
                rd_last    <= 1'b1;
                pend_vld   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pbit_histogram_collector.sv
// Directed bench for pbit_histogram_collector (NUM_OUT=2, CNT_W=2).
module tb_pbit_histogram_collector;
    logic       clk = 1'b0;
    logic       reset_n, sample_valid, start, rd_ready;
    logic [1:0] sample_data;
    logic [31:0] num_samples;
    logic       busy, done, sat_flag, rd_valid, rd_last;
    logic [1:0] rd_pattern, rd_count;

    int n_tot = 0, n_bad = 0;
    int done_cnt = 0, rv_cnt = 0;
    int bp[$], bc[$], bl[$];

    pbit_histogram_collector #(.NUM_OUT(2), .CNT_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_data(sample_data), .start(start), .num_samples(num_samples),
        .busy(busy), .done(done), .sat_flag(sat_flag), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_pattern(rd_pattern), .rd_count(rd_count),
        .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    // Record transferred beats and done pulses away from the active edge.
    always @(negedge clk) begin
        if (rd_valid && rd_ready) begin
            bp.push_back(int'(rd_pattern));
            bc.push_back(int'(rd_count));
            bl.push_back(int'(rd_last));
        end
        if (done) done_cnt++;
        if (rd_valid) rv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input int k, input int p, input int c, input int l);
        if (k >= bp.size()) begin
            chk($sformatf("beat%0d_missing", k), 32'(bp.size()), 32'(k + 1));
        end else begin
            chk($sformatf("beat%0d_pat", k), 32'(bp[k]), 32'(p));
            chk($sformatf("beat%0d_cnt", k), 32'(bc[k]), 32'(c));
            chk($sformatf("beat%0d_last", k), 32'(bl[k]), 32'(l));
        end
    endtask

    task automatic do_start(input int n);
        @(posedge clk); #1;
        start = 1'b1; num_samples = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive one sample per cycle, back-to-back.
    task automatic send(input int s);
        sample_valid = 1'b1; sample_data = 2'(s);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int i;
        for (i = 0; i < 300; i++) begin
            @(posedge clk);
            if (done_cnt > d0) break;
        end
        if (i == 300) chk({tag, "_timeout"}, 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int b0, d0, r0, nclr, unstable;
        logic [1:0] hp, hc;
        logic hl;
        reset_n = 1'b0; sample_valid = 1'b0; sample_data = '0;
        start = 1'b0; num_samples = '0; rd_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_rvalid", rd_valid, 0);
        chk("rst_rlast", rd_last, 0);
        chk("rst_rpat", rd_pattern, 0);
        chk("rst_rcnt", rd_count, 0);
        chk("rst_scnt", dut.sample_cnt, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // Back-to-back with repeated bin: expect (1,3),(3,1,last)
        b0 = bp.size(); d0 = done_cnt;
        do_start(4);
        repeat (4) @(posedge clk); #1;
        send(1); send(1); send(3); send(1);
        wait_done(d0, "t1");
        chk("t1_nbeats", bp.size() - b0, 2);
        chk_beat(b0, 1, 3, 0);
        chk_beat(b0 + 1, 3, 1, 1);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_sat", sat_flag, 0);
        chk("t1_busy", busy, 0);

        // Saturation: five samples into a 2-bit bin -> (2,3,last), sat set
        b0 = bp.size(); d0 = done_cnt;
        do_start(5);
        repeat (4) @(posedge clk); #1;
        repeat (5) send(2);
        wait_done(d0, "t2");
        chk("t2_nbeats", bp.size() - b0, 1);
        chk_beat(b0, 2, 3, 1);
        chk("t2_sat", sat_flag, 1);

        // Zero samples: CLEAR 4 cycles, no beats, done once, sat cleared
        b0 = bp.size(); d0 = done_cnt; r0 = rv_cnt; nclr = 0;
        do_start(0);
        chk("t3_sat_clr", sat_flag, 0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (int'(dut.state_q) == 1) nclr++;
            if (!busy) break;
        end
        @(posedge clk); #1;
        chk("t3_clear_cycles", nclr, 4);
        chk("t3_nbeats", bp.size() - b0, 0);
        chk("t3_rvalid_never", rv_cnt - r0, 0);
        chk("t3_done", done_cnt - d0, 1);

        // Backpressure on first beat: hold 5 cycles, then (0,1),(2,2),(3,1,last)
        b0 = bp.size(); d0 = done_cnt; unstable = 0;
        rd_ready = 1'b0;
        do_start(4);
        repeat (4) @(posedge clk); #1;
        send(0); send(2); send(2); send(3);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rd_valid) break;
        end
        chk("t4_first_valid", rd_valid, 1);
        hp = rd_pattern; hc = rd_count; hl = rd_last;
        chk("t4_first_pat", hp, 0);
        repeat (5) begin
            @(negedge clk);
            if (!rd_valid || rd_pattern !== hp || rd_count !== hc || rd_last !== hl) unstable++;
        end
        chk("t4_stable", unstable, 0);
        rd_ready = 1'b1;
        wait_done(d0, "t4");
        chk("t4_nbeats", bp.size() - b0, 3);
        chk_beat(b0, 0, 1, 0);
        chk_beat(b0 + 1, 2, 2, 0);
        chk_beat(b0 + 2, 3, 1, 1);

        // Samples during CLEAR and after the target count are ignored
        b0 = bp.size(); d0 = done_cnt;
        do_start(3);
        send(1); send(1);
        repeat (2) @(posedge clk); #1;
        send(0); send(0); send(0); send(1); send(1);
        wait_done(d0, "t5");
        chk("t5_scnt", dut.sample_cnt, 3);
        chk("t5_nbeats", bp.size() - b0, 1);
        chk_beat(b0, 0, 3, 1);

        // Reset mid-COLLECT abandons the run; fresh run sees no stale counts
        d0 = done_cnt;
        do_start(4);
        repeat (4) @(posedge clk); #1;
        send(1); send(2);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_scnt", dut.sample_cnt, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        b0 = bp.size(); d0 = done_cnt;
        do_start(2);
        repeat (4) @(posedge clk); #1;
        send(0); send(0);
        wait_done(d0, "t6");
        chk("t6_nbeats", bp.size() - b0, 1);
        chk_beat(b0, 0, 2, 1);
        chk("t6_done", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
